corr_peak_finder: RTL and testbench
===================================

CORR_PEAK_FINDER -- requirements
Module: corr_peak_finder

Interface
REQ-001 Parameter NLAGS, default 5, SHALL set the number of autocorrelation lags per frame.
REQ-002 Parameter LAG_W, default 2, SHALL set the width in bits of each lag value.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  SHALL indicate that in_lags holds a complete lag frame from the upstream correlator.
REQ-006 in_lags  input  NLAGS*LAG_W  SHALL carry the frame, with lag i at bits [i*LAG_W +: LAG_W].
REQ-007 in_ready  output  1  SHALL be high only while the block can accept a frame.
REQ-008 out_valid  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-009 out_peak  output  LAG_W  SHALL carry the largest lag value of the frame.
REQ-010 out_index  output  $clog2(NLAGS)  SHALL carry the index of that lag value.
REQ-011 out_sym  output  1  SHALL flag a frame that is symmetric, i.e. lag[i]==lag[NLAGS-1-i] for all i.
REQ-012 drop_cnt  output  4  SHALL count frames offered while the block was busy; the count saturates.

Function
REQ-013 The block SHALL use FSM states IDLE, SCAN and DONE.
REQ-014 IDLE: in_ready SHALL be 1; when in_valid=1 at edge T, the block SHALL register in_lags, go to SCAN and clear the scan index to 0.
REQ-015 SCAN SHALL examine one lag per cycle, at indices 0..NLAGS-1 on edges T+1..T+NLAGS.
REQ-016 SCAN SHALL go to DONE after index NLAGS-1 is examined.
REQ-017 Comparison SHALL be unsigned; a new maximum SHALL be taken only when strictly greater, so the lowest index wins ties.
REQ-018 An all-zero frame SHALL give out_peak=0 and out_index=0.
REQ-019 DONE SHALL assert out_valid for exactly one cycle, then return to IDLE, giving frame-to-frame spacing of NLAGS+2 cycles.
REQ-020 Latency SHALL be NLAGS+1 cycles from the accept edge to the edge that raises out_valid (6 for the default).
REQ-021 out_peak, out_index and out_sym SHALL hold their last result until the next DONE.
REQ-022 in_valid=1 in SCAN or DONE SHALL increment drop_cnt once per cycle, saturating at 15, and SHALL NOT disturb the frame in progress.
REQ-023 drop_cnt SHALL NOT wrap.
REQ-024 in_ready SHALL be combinational from state only, never from in_valid.
REQ-025 The scan index SHALL NOT exceed NLAGS-1; any unreachable state SHALL recover to IDLE.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE and set out_valid=0, out_peak=0, out_index=0, out_sym=0 and drop_cnt=0.
REQ-027 Reset during SCAN or DONE SHALL abandon the frame with no out_valid pulse.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n returns high.

Configuration
REQ-029 Macro CORR_SYM_CHECK_EN SHALL control symmetry checking.
REQ-030 With CORR_SYM_CHECK_EN defined, out_sym SHALL be computed during SCAN by comparing lag[i] with lag[NLAGS-1-i] for i<NLAGS/2, and SHALL be registered at DONE.
REQ-031 Without CORR_SYM_CHECK_EN, out_sym SHALL be tied to 0 and no comparison logic SHALL be built; the port SHALL remain present.

Structure
REQ-032 Shared package corr_pkg SHALL hold NLAGS, LAG_W, IDX_W=$clog2(NLAGS) and the FSM state enum.
REQ-033 The upstream correlator SHALL use the same NLAGS and LAG_W from corr_pkg.
REQ-034 A sub-module corr_sym_check SHALL contain the per-cycle symmetry comparator; it is instantiated only under CORR_SYM_CHECK_EN.

Verification
REQ-035 Bench SHALL apply frame lags {0,1,3,1,0} with in_valid at cycle T -> out_valid at T+6, out_peak=3, out_index=2, out_sym=1 (0 without the macro).
REQ-036 Bench SHALL apply tie frame {2,2,1,0,0} -> out_peak=2, out_index=0, out_sym=0.
REQ-037 Bench SHALL apply an all-zero frame -> out_peak=0, out_index=0, out_sym=1 (with the macro).
REQ-038 Bench SHALL hold in_valid high continuously for 20 cycles -> exactly one accept per 7 cycles, and drop_cnt climbs to 15 and holds there.
REQ-039 Bench SHALL pulse rst_n low at T+3 mid-scan -> no out_valid, all outputs 0, in_ready=1 on the next cycle.
REQ-040 Bench SHALL send back-to-back frames {3,0,0,0,0} then {0,0,0,0,3} -> results index 0 then index 4, and out_peak holds 3 between the pulses.

Source files
------------

// File: rtl/corr_pkg.sv
// corr_pkg: frame geometry shared by the peak finder and the upstream correlator,
// plus the peak finder FSM encoding.
package corr_pkg;
  localparam int NLAGS = 5;
  localparam int LAG_W = 2;
  localparam int IDX_W = $clog2(NLAGS);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/corr_sym_check.sv
// corr_sym_check: flags a lag that differs from its mirror lag; only the lower half
// of the frame is compared since the upper half mirrors it.
module corr_sym_check
  import corr_pkg::*;
#(
  parameter int NLAGS = corr_pkg::NLAGS,
  parameter int LAG_W = corr_pkg::LAG_W,
  localparam int IDX_W = $clog2(NLAGS)
) (
  input  logic [NLAGS*LAG_W-1:0] lags_i,
  input  logic [IDX_W-1:0]       idx_i,
  output logic                   mis_o
);
  logic [IDX_W-1:0] mir;
  logic [LAG_W-1:0] a, b;
  assign mir = IDX_W'(NLAGS - 1) - idx_i;
  assign a = LAG_W'(lags_i >> (LAG_W * int'(idx_i)));
  assign b = LAG_W'(lags_i >> (LAG_W * int'(mir)));
  assign mis_o = (idx_i < IDX_W'(NLAGS / 2)) && (a != b);
endmodule

// File: rtl/corr_peak_finder.sv
// corr_peak_finder: serial one-lag-per-cycle peak search over an autocorrelation frame.
// Symmetry flag is built only when CORR_SYM_CHECK_EN is defined; otherwise out_sym is 0.
module corr_peak_finder
  import corr_pkg::*;
#(
  parameter int NLAGS = corr_pkg::NLAGS,
  parameter int LAG_W = corr_pkg::LAG_W,
  localparam int IDX_W = $clog2(NLAGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [NLAGS*LAG_W-1:0] in_lags,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [LAG_W-1:0]       out_peak,
  output logic [IDX_W-1:0]       out_index,
  output logic                   out_sym,
  output logic [3:0]             drop_cnt
);
  state_t                 state_q, state_d;
  logic [NLAGS*LAG_W-1:0] lags_q, lags_d;
  logic [IDX_W-1:0]       idx_q, idx_d, maxi_q, maxi_d, index_q;
  logic [LAG_W-1:0]       max_q, max_d, peak_q, lag_cur;
  logic [3:0]             drop_q, drop_d;
  logic                   valid_q, last;
  assign lag_cur = LAG_W'(lags_q >> (LAG_W * int'(idx_q)));
  assign last = idx_q == IDX_W'(NLAGS - 1);
  assign in_ready = state_q == IDLE;
  assign out_valid = valid_q;
  assign out_peak = peak_q;
  assign out_index = index_q;
  assign drop_cnt = drop_q;
  assign drop_d = (in_valid && (state_q == SCAN || state_q == DONE) && drop_q != 4'hf) ? drop_q + 4'd1 : drop_q;
  always_comb begin
    state_d = state_q;
    lags_d = lags_q;
    idx_d = idx_q;
    max_d = max_q;
    maxi_d = maxi_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SCAN;
        lags_d = in_lags;
        idx_d = '0;
        max_d = '0;
        maxi_d = '0;
      end
      SCAN: begin
        // strict compare keeps the lowest index on ties
        max_d = (lag_cur > max_q) ? lag_cur : max_q;
        maxi_d = (lag_cur > max_q) ? idx_q : maxi_q;
        idx_d = last ? '0 : idx_q + 1'b1;
        state_d = last ? DONE : SCAN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lags_q <= '0;
      idx_q <= '0;
      max_q <= '0;
      maxi_q <= '0;
      valid_q <= 1'b0;
      peak_q <= '0;
      index_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      lags_q <= lags_d;
      idx_q <= idx_d;
      max_q <= max_d;
      maxi_q <= maxi_d;
      valid_q <= state_q == DONE;
      peak_q <= (state_q == DONE) ? max_q : peak_q;
      index_q <= (state_q == DONE) ? maxi_q : index_q;
      drop_q <= drop_d;
    end
  end
`ifdef CORR_SYM_CHECK_EN
  logic sym_run_q, sym_q, mis;
  corr_sym_check #(.NLAGS(NLAGS), .LAG_W(LAG_W)) u_sym (
    .lags_i(lags_q),
    .idx_i (idx_q),
    .mis_o (mis)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_run_q <= 1'b0;
      sym_q <= 1'b0;
    end else begin
      sym_run_q <= (state_q == IDLE && in_valid) ? 1'b1 : (state_q == SCAN && mis) ? 1'b0 : sym_run_q;
      sym_q <= (state_q == DONE) ? sym_run_q : sym_q;
    end
  end
  assign out_sym = sym_q;
`else
  assign out_sym = 1'b0;
`endif
endmodule

// File: tb/tb_corr_peak_finder.sv
// tb_corr_peak_finder: directed and randomized frames checked against a behavioural
// model of peak/index/symmetry, latency, result hold and saturating drop count.
module tb_corr_peak_finder;
  localparam int N = 5;
  localparam int W = 2;
`ifdef CORR_SYM_CHECK_EN
  localparam int SYM_EN = 1;
`else
  localparam int SYM_EN = 0;
`endif
  logic clk, rst_n, in_valid, in_ready, out_valid, out_sym;
  logic [N*W-1:0] in_lags;
  logic [W-1:0] out_peak;
  logic [2:0] out_index;
  logic [3:0] drop_cnt;
  int n_chk, n_err, prev_peak, drop_exp;
  bit noisy;
  corr_peak_finder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_lags  (in_lags),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_peak (out_peak),
    .out_index(out_index),
    .out_sym  (out_sym),
    .drop_cnt (drop_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [N*W-1:0] pk(input int a0, input int a1, input int a2, input int a3, input int a4);
    logic [W-1:0] v [N];
    logic [N*W-1:0] f;
    v[0] = W'(a0); v[1] = W'(a1); v[2] = W'(a2); v[3] = W'(a3); v[4] = W'(a4);
    for (int i = 0; i < N; i++) f[i*W +: W] = v[i];
    return f;
  endfunction
  function automatic void model(input logic [N*W-1:0] f, output int p, output int ix, output int s);
    int v [N];
    for (int i = 0; i < N; i++) v[i] = int'(f[i*W +: W]);
    p = 0; ix = 0; s = 1;
    for (int i = 0; i < N; i++) if (v[i] > p) begin p = v[i]; ix = i; end
    for (int i = 0; i < N; i++) if (v[i] != v[N-1-i]) s = 0;
    if (SYM_EN == 0) s = 0;
  endfunction
  task automatic do_reset;
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    prev_peak = 0;
    drop_exp = 0;
  endtask
  task automatic send(input logic [N*W-1:0] f);
    chk("ready_before_send", in_ready, 1);
    in_lags = f;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    in_lags = (N*W)'($urandom);
  endtask
  task automatic wait_result(input int ep, input int ei, input int es);
    int lat;
    bit hold_bad;
    lat = 0;
    hold_bad = 0;
    while (!out_valid && lat < 20) begin
      if (int'(out_peak) != prev_peak) hold_bad = 1;
      in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (in_valid) begin
        in_lags = (N*W)'($urandom);
        if (drop_exp < 15) drop_exp++;
      end
      tick;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, N + 1);
    chk("peak_hold", hold_bad, 0);
    chk("peak", out_peak, ep);
    chk("index", out_index, ei);
    chk("sym", out_sym, es);
    chk("drop", drop_cnt, drop_exp);
    prev_peak = ep;
  endtask
  initial begin
    int p, ix, s, seen, exp_drop;
    logic [N*W-1:0] f;
    n_chk = 0; n_err = 0; noisy = 0;
    in_valid = 1'b0; in_lags = '0; rst_n = 1'b0;
    tick;
    do_reset;
    chk("rst_valid", out_valid, 0);
    chk("rst_peak", out_peak, 0);
    chk("rst_index", out_index, 0);
    chk("rst_sym", out_sym, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ready", in_ready, 1);
    send(pk(0, 1, 3, 1, 0));
    wait_result(3, 2, SYM_EN);
    tick;
    chk("pulse_width", out_valid, 0);
    send(pk(2, 2, 1, 0, 0));
    wait_result(2, 0, 0);
    send(pk(0, 0, 0, 0, 0));
    wait_result(0, 0, SYM_EN);
    send(pk(3, 0, 0, 0, 0));
    wait_result(3, 0, 0);
    send(pk(0, 0, 0, 0, 3));
    wait_result(3, 4, 0);
    do_reset;
    noisy = 1;
    for (int k = 0; k < 40; k++) begin
      f = (N*W)'($urandom);
      if (k % 8 == 0) f = pk(1, 2, 3, 2, 1);
      model(f, p, ix, s);
      send(f);
      wait_result(p, ix, s);
      repeat ($urandom_range(0, 2)) tick;
    end
    noisy = 0;
    do_reset;
    send(pk(0, 1, 3, 1, 0));
    wait_result(3, 2, SYM_EN);
    send(pk(3, 2, 1, 0, 1));
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_peak", out_peak, 0);
    chk("midrst_index", out_index, 0);
    chk("midrst_sym", out_sym, 0);
    chk("midrst_drop", drop_cnt, 0);
    chk("midrst_ready", in_ready, 1);
    seen = 0;
    repeat (10) begin
      tick;
      if (out_valid) seen++;
    end
    chk("midrst_no_pulse", seen, 0);
    exp_drop = 0;
    in_lags = (N*W)'($urandom);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("cont_ready", in_ready, (k % 7) == 0);
      tick;
      if ((k % 7) != 0 && exp_drop < 15) exp_drop++;
      chk("cont_drop", drop_cnt, exp_drop);
      chk("cont_out_valid", out_valid, (k % 7) == 6);
    end
    in_valid = 1'b0;
    repeat (8) tick;
    chk("cont_drop_hold", drop_cnt, 15);
    chk("cont_idle_ready", in_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
